eth_pkt_buf_ctrl: RTL and testbench

- Single-clock packet buffer controller. It sequences one internal mem_1r1w_sync instance (width_p+1 bits wide, els_p deep; the extra bit is the last flag).
- Input side accepts frames as a ready/valid word stream, commits them on the last word, and discards them on error or overflow.
- Output side streams only committed frames. It hides the 1-cycle synchronous read latency behind a 2-entry output skid buffer.
- Sits between the Ethernet RX MAC word path and the host-facing DMA/stream interface.

---
 rtl/eth_pkt_buf_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_eth_pkt_buf_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_buf_ctrl.sv
// Packet buffer controller: commits ready/valid frames into a 1R1W synchronous RAM
// and streams only committed frames out through a 2-entry skid buffer.
module eth_pkt_buf_ctrl #(
    parameter int unsigned width_p         = 32,
    parameter int unsigned els_p           = 512,
    parameter int unsigned pkt_cnt_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       in_v_i,
    input  logic [width_p-1:0]         in_data_i,
    input  logic                       in_last_i,
    input  logic                       in_err_i,
    output logic                       in_ready_o,
    output logic                       out_v_o,
    output logic [width_p-1:0]         out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i,
    output logic [pkt_cnt_width_p-1:0] pkt_count_o,
    output logic                       overflow_o,
    output logic                       drop_o
);

    localparam int unsigned AddrW = $clog2(els_p);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned MemW  = width_p + 1;
    localparam logic [PtrW-1:0]            PtrOne = PtrW'(1);
    localparam logic [PtrW-1:0]            Depth  = PtrW'(els_p);
    localparam logic [pkt_cnt_width_p-1:0] PktOne = pkt_cnt_width_p'(1);

    typedef struct packed {
        logic               last;
        logic [width_p-1:0] data;
    } word_t;

    typedef enum logic {eRecv, eDrop} wstate_e;

    wstate_e                    state_q, state_d;
    logic                       alive_q;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            commit_ptr_q, commit_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]            rd_issue_ptr_q, rd_issue_ptr_d;
    logic                       inflight_q, inflight_d;
    word_t [1:0]                skid_q, skid_d;
    logic                       head_q, head_d;
    logic [1:0]                 skid_cnt_q, skid_cnt_d;
    logic [pkt_cnt_width_p-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                       overflow_q, overflow_d;
    logic                       drop_q, drop_d;

    logic [PtrW-1:0] occupancy;
    logic            full;
    logic            ovf_c;
    logic            in_hs;
    logic            wr_v;
    logic            r_v;
    logic            out_hs;
    logic            pop_last;
    logic            pkt_inc;
    word_t           wr_word;
    word_t           rd_word;
    word_t           head_word;
    logic [MemW-1:0] rd_data_raw;

    // Free space is measured from the consumer pointer, not the read-issue pointer.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (occupancy == Depth);
    // A frame that alone fills the buffer can never commit, so it must be dropped.
    assign ovf_c     = (state_q == eRecv) && full && (commit_ptr_q == rd_ptr_q);

    assign in_ready_o = alive_q && ((state_q == eDrop) || !full || ovf_c);
    assign in_hs      = in_v_i && in_ready_o;
    assign wr_v       = in_hs && (state_q == eRecv) && !full;
    assign wr_word    = '{last: in_last_i, data: in_data_i};

    assign head_word  = skid_q[head_q];
    assign out_v_o    = (skid_cnt_q != 2'd0);
    assign out_data_o = head_word.data;
    assign out_last_o = head_word.last;
    assign out_hs     = out_v_o && out_ready_i;
    assign pop_last   = out_hs && out_last_o;

    // An entry popped this cycle frees a slot, keeping one word per cycle sustained.
    assign r_v = (rd_issue_ptr_q != commit_ptr_q) &&
                 ((3'(skid_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(out_hs)));

    assign rd_word     = rd_data_raw;
    assign pkt_count_o = pkt_cnt_q;
    assign overflow_o  = overflow_q;
    assign drop_o      = drop_q;

    mem_1r1w_sync #(
        .width_p     (MemW),
        .els_p       (els_p),
        .addr_width_p(AddrW)
    ) u_mem (
        .clk_i   (clk_i),
        .w_v_i   (wr_v),
        .w_addr_i(wr_ptr_q[AddrW-1:0]),
        .w_data_i(wr_word),
        .r_v_i   (r_v),
        .r_addr_i(rd_issue_ptr_q[AddrW-1:0]),
        .r_data_o(rd_data_raw)
    );

    // Next-state logic for write FSM, read sequencing, skid buffer and counters.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        commit_ptr_d   = commit_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        rd_issue_ptr_d = rd_issue_ptr_q;
        inflight_d     = r_v;
        skid_d         = skid_q;
        head_d         = head_q;
        skid_cnt_d     = skid_cnt_q;
        pkt_cnt_d      = pkt_cnt_q;
        overflow_d     = 1'b0;
        drop_d         = 1'b0;
        pkt_inc        = 1'b0;

        case (state_q)
            eRecv: begin
                if (ovf_c) begin
                    wr_ptr_d   = commit_ptr_q;
                    overflow_d = 1'b1;
                    if (!(in_hs && in_last_i)) begin
                        state_d = eDrop;
                    end
                end else if (wr_v) begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    if (in_last_i) begin
                        if (in_err_i) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_d   = 1'b1;
                        end else begin
                            commit_ptr_d = wr_ptr_q + PtrOne;
                            pkt_inc      = 1'b1;
                        end
                    end
                end
            end
            eDrop: begin
                if (in_hs && in_last_i) begin
                    state_d = eRecv;
                end
            end
            default: state_d = eRecv;
        endcase

        if (r_v) begin
            rd_issue_ptr_d = rd_issue_ptr_q + PtrOne;
        end

        if (inflight_q) begin
            skid_d[head_q ^ skid_cnt_q[0]] = rd_word;
        end
        if (out_hs) begin
            head_d   = ~head_q;
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        skid_cnt_d = 2'(skid_cnt_q + 2'(inflight_q) - 2'(out_hs));

        if (pkt_inc && !pop_last) begin
            if (pkt_cnt_q != '1) begin
                pkt_cnt_d = pkt_cnt_q + PktOne;
            end
        end else if (!pkt_inc && pop_last) begin
            if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - PktOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= eRecv;
            alive_q        <= 1'b0;
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            rd_ptr_q       <= '0;
            rd_issue_ptr_q <= '0;
            inflight_q     <= 1'b0;
            skid_q         <= '0;
            head_q         <= 1'b0;
            skid_cnt_q     <= 2'd0;
            pkt_cnt_q      <= '0;
            overflow_q     <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            alive_q        <= 1'b1;
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_issue_ptr_q <= rd_issue_ptr_d;
            inflight_q     <= inflight_d;
            skid_q         <= skid_d;
            head_q         <= head_d;
            skid_cnt_q     <= skid_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
            overflow_q     <= overflow_d;
            drop_q         <= drop_d;
        end
    end

endmodule

// One write port, one synchronous read port; contents are never reset.
module mem_1r1w_sync #(
    parameter int unsigned width_p      = 8,
    parameter int unsigned els_p        = 4,
    parameter int unsigned addr_width_p = 2
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic                    r_v_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
        if (r_v_i) begin
            r_data_o <= mem_q[r_addr_i];
        end
    end

endmodule

// File: tb/tb_eth_pkt_buf_ctrl.sv
// Bench for eth_pkt_buf_ctrl: cycle table for latency/drop, then scoreboarded
// sequences for overflow, back-pressure, random stalls with wrap, and mid-frame reset.
module tb_eth_pkt_buf_ctrl;

    localparam int unsigned W   = 32;
    localparam int unsigned ELS = 8;
    localparam int unsigned PCW = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_v, in_last, in_err, in_ready;
    logic [W-1:0]   in_data;
    logic           out_v, out_last;
    logic [W-1:0]   out_data;
    logic           out_ready = 1'b1;
    logic [PCW-1:0] pkt_count;
    logic           overflow, drop;

    always #5 clk = ~clk;

    eth_pkt_buf_ctrl #(.width_p(W), .els_p(ELS), .pkt_cnt_width_p(PCW)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .in_v_i     (in_v),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .in_err_i   (in_err),
        .in_ready_o (in_ready),
        .out_v_o    (out_v),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_ready_i(out_ready),
        .pkt_count_o(pkt_count),
        .overflow_o (overflow),
        .drop_o     (drop)
    );

    typedef struct {
        logic           v;
        logic [W-1:0]   d;
        logic           last;
        logic           err;
        logic           e_ready;
        logic           e_ov;
        logic [W-1:0]   e_d;
        logic           e_last;
        logic [PCW-1:0] e_pkt;
        logic           e_drop;
    } vec_t;

    vec_t tv [18];

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    int drop_cnt = 0;
    int hs_cnt = 0;
    int rdy_mode = 1;
    bit mon_en = 1'b0;
    logic [W:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready pattern: 0 = hold low, 1 = hold high, else random.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output scoreboard: any visible word must be the next expected one, stalled or not.
    always @(negedge clk) begin
        logic [W:0] e;
        #2;
        if (overflow) ovf_cnt++;
        if (drop) drop_cnt++;
        if (reset_n && mon_en && out_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %0h expected no output at %0t", out_data, $time);
            end else begin
                e = exp_q[0];
                chk("out_data", out_data, e[W-1:0]);
                chk("out_last", 32'(out_last), 32'(e[W]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    task automatic drive_word(input logic [W-1:0] d, input logic last, input logic err);
        in_v    = 1'b1;
        in_data = d;
        in_last = last;
        in_err  = err;
    endtask

    task automatic wait_ready(input string name);
        int b = 0;
        while (!in_ready && b < 300) begin
            @(negedge clk);
            #1;
            b++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s_ready_timeout: got in_ready=0 expected 1 within 300 cycles", name);
        end
    endtask

    task automatic send_frame(input int len, input logic [W-1:0] base, input logic err,
                              input bit push, input bit chk_rdy);
        if (push) begin
            for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), W'(base + W'(k))});
        end
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            drive_word(W'(base + W'(k)), (k == len - 1), err && (k == len - 1));
            #1;
            if (chk_rdy) chk($sformatf("word%0d_in_ready", k), 32'(in_ready), 32'(1));
            wait_ready("send");
        end
        @(negedge clk);
        in_v = 1'b0; in_last = 1'b0; in_err = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        while (exp_q.size() != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        chk($sformatf("%s_remaining_words", name), 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, d0, h0, n_err, b;
        logic [W-1:0] a_w, b_w, c_w, d_w;
        a_w = 32'hA0A0_0001; b_w = 32'hA0A0_0002; c_w = 32'hA0A0_0003; d_w = 32'hD00D_0004;
        reset_n = 1'b0; in_v = 1'b0; in_data = '0; in_last = 1'b0; in_err = 1'b0;

        //          v     data          last  err   rdy   ov    out_d  olast pkt   drop
        tv[0]  = '{1'b1, a_w,           1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[1]  = '{1'b1, b_w,           1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[2]  = '{1'b1, c_w,           1'b1, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[3]  = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd1, 1'b0};
        tv[4]  = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd1, 1'b0};
        tv[5]  = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b1, a_w,   1'b0, 8'd1, 1'b0};
        tv[6]  = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b1, b_w,   1'b0, 8'd1, 1'b0};
        tv[7]  = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b1, c_w,   1'b1, 8'd1, 1'b0};
        tv[8]  = '{1'b1, 32'hE000_0000, 1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[9]  = '{1'b1, 32'hE000_0001, 1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[10] = '{1'b1, 32'hE000_0002, 1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[11] = '{1'b1, 32'hE000_0003, 1'b1, 1'b1, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[12] = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b1};
        tv[13] = '{1'b1, d_w,           1'b1, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};
        tv[14] = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd1, 1'b0};
        tv[15] = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd1, 1'b0};
        tv[16] = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b1, d_w,   1'b1, 8'd1, 1'b0};
        tv[17] = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 1'b0, '0,    1'b0, 8'd0, 1'b0};

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_v", 32'(out_v), 32'(0));
        chk("rst_pkt_count", 32'(pkt_count), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_drop", 32'(drop), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 3-word frame latency/order, then errored frame drop and pointer restore
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_v = tv[i].v; in_data = tv[i].d; in_last = tv[i].last; in_err = tv[i].err;
            #1;
            chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tv[i].e_ready));
            chk($sformatf("row%0d_out_v", i), 32'(out_v), 32'(tv[i].e_ov));
            chk($sformatf("row%0d_pkt_count", i), 32'(pkt_count), 32'(tv[i].e_pkt));
            chk($sformatf("row%0d_drop", i), 32'(drop), 32'(tv[i].e_drop));
            chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'(0));
            if (tv[i].e_ov) begin
                chk($sformatf("row%0d_out_data", i), out_data, tv[i].e_d);
                chk($sformatf("row%0d_out_last", i), 32'(out_last), 32'(tv[i].e_last));
            end
        end
        mon_en = 1'b1;

        // Oversized frame on an empty buffer: dropped with one overflow pulse
        o0 = ovf_cnt;
        send_frame(10, 32'h1000_0000, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("ovf_pulse_count", 32'(ovf_cnt - o0), 32'(1));
        send_frame(2, 32'h2000_0000, 1'b0, 1'b1, 1'b1);
        wait_drain("after_ovf");

        // Full with committed data: back-pressure only, then both frames in order
        o0 = ovf_cnt;
        h0 = hs_cnt;
        rdy_mode = 0;
        send_frame(6, 32'h3000_0000, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), W'(32'h4000_0000 + k)});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_word(W'(32'h4000_0000 + k), 1'b0, 1'b0);
            #1;
            chk($sformatf("bp_word%0d_in_ready", k), 32'(in_ready), 32'(1));
        end
        @(negedge clk);
        drive_word(32'h4000_0002, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_full%0d_in_ready", k), 32'(in_ready), 32'(0));
            @(negedge clk);
        end
        chk("bp_no_overflow", 32'(ovf_cnt - o0), 32'(0));
        rdy_mode = 1;
        #1;
        wait_ready("bp_w2");
        @(negedge clk);
        drive_word(32'h4000_0003, 1'b1, 1'b0);
        #1;
        wait_ready("bp_w3");
        @(negedge clk);
        in_v = 1'b0; in_last = 1'b0;
        wait_drain("backpressure");
        chk("bp_words_out", 32'(hs_cnt - h0), 32'(10));
        chk("bp_pkt_count", 32'(pkt_count), 32'(0));

        // Random stalls over 20 frames, some errored, wrapping the pointers repeatedly
        rdy_mode = 2;
        d0 = drop_cnt;
        o0 = ovf_cnt;
        n_err = 0;
        for (int f = 0; f < 20; f++) begin
            int len;
            logic e;
            len = int'($urandom_range(1, 6));
            e   = ($urandom_range(0, 4) == 0);
            if (e) n_err++;
            send_frame(len, W'(32'h5000_0000 + (f << 8)), e, !e, 1'b0);
        end
        wait_drain("random");
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        chk("rand_drop_count", 32'(drop_cnt - d0), 32'(n_err));
        chk("rand_no_overflow", 32'(ovf_cnt - o0), 32'(0));
        chk("rand_pkt_count", 32'(pkt_count), 32'(0));

        // Reset while the second of two committed frames is being output
        rdy_mode = 0;
        send_frame(3, 32'h6000_0000, 1'b0, 1'b1, 1'b1);
        send_frame(3, 32'h7000_0000, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_pkt_count", 32'(pkt_count), 32'(2));
        h0 = hs_cnt;
        rdy_mode = 1;
        b = 0;
        while ((hs_cnt - h0) < 4 && b < 100) begin
            @(negedge clk);
            #3;
            b++;
        end
        chk("pre_rst_words_out", 32'(hs_cnt - h0), 32'(4));
        @(negedge clk);
        chk("pre_rst_mid_frame_v", 32'(out_v), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_v", 32'(out_v), 32'(0));
        chk("async_rst_pkt_count", 32'(pkt_count), 32'(0));
        chk("async_rst_in_ready", 32'(in_ready), 32'(0));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_out_v", 32'(out_v), 32'(0));
        chk("post_rst_pkt_count", 32'(pkt_count), 32'(0));
        repeat (6) @(negedge clk);
        h0 = hs_cnt;
        send_frame(2, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        wait_drain("post_reset");
        chk("post_rst_words_out", 32'(hs_cnt - h0), 32'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
